// File: rtl/mod14_seq_checker_pkg.sv
// rtl/mod14_seq_checker_pkg.sv - shared types and prediction function for the mod-14 counter checker
package mod14_seq_checker_pkg;

    localparam int MOD_DEFAULT = 14;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } chk_state_t;

    // Exact model of the counter, including loaded values at or above the modulus.
    function automatic logic [3:0] nxt(
        input logic [3:0] v,
        input logic       clr,
        input logic       load,
        input logic       mode,
        input logic [3:0] din,
        input logic [3:0] last
    );
        if (clr)
            return 4'd0;
        else if (load)
            return din;
        else if (mode)
            return (v == last) ? 4'd0 : v + 4'd1;
        else
            return (v == 4'd0) ? last : v - 4'd1;
    endfunction

endpackage

// File: rtl/mod14_seq_checker_next_pred.sv
// rtl/mod14_seq_checker_next_pred.sv - combinational next-value prediction
module mod14_next_pred
    import mod14_seq_checker_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT
) (
    input  logic [3:0] v,
    input  logic       clr,
    input  logic       load,
    input  logic       mode,
    input  logic [3:0] din,
    output logic [3:0] nxt_v
);

    localparam logic [3:0] LAST = 4'(MOD - 1);

    assign nxt_v = nxt(v, clr, load, mode, din, LAST);

endmodule

// File: rtl/mod14_seq_checker.sv
// rtl/mod14_seq_checker.sv - observer that predicts and checks the mod-14 counter output
module mod14_seq_checker
    import mod14_seq_checker_pkg::*;
#(
    parameter int MOD   = MOD_DEFAULT,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             chk_en,
    input  logic             err_clr,
    input  logic             ctr_clr,
    input  logic             ctr_load,
    input  logic             ctr_mode,
    input  logic [3:0]       ctr_din,
    input  logic [3:0]       ctr_dout,
    output logic             in_sync,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             oor
);

    localparam logic [3:0]       LAST    = 4'(MOD - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_t state;
    logic [3:0] pred;
    logic [3:0] prev_dout;
    logic       prev_mode;
    logic       track_ok;
    logic       mismatch;

    mod14_next_pred #(.MOD(MOD)) u_pred (
        .v     (ctr_dout),
        .clr   (ctr_clr),
        .load  (ctr_load),
        .mode  (ctr_mode),
        .din   (ctr_din),
        .nxt_v (pred)
    );

    assign track_ok = (state == TRACK) && chk_en;
    assign mismatch = track_ok && (ctr_dout != expected);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UNSYNC;
            in_sync    <= 1'b0;
            expected   <= 4'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            oor        <= 1'b0;
            prev_dout  <= 4'd0;
            prev_mode  <= 1'b0;
        end else begin
            // Predicting from the observed value (not the previous prediction) resynchronises after a fault.
            expected  <= pred;
            prev_dout <= ctr_dout;
            prev_mode <= ctr_mode;
            err_pulse <= mismatch;

            if (err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else if (mismatch) begin
                err_sticky <= 1'b1;
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
            end

            wrap_up <= track_ok && prev_mode  && (prev_dout == LAST) && (ctr_dout == 4'd0);
            wrap_dn <= track_ok && !prev_mode && (prev_dout == 4'd0) && (ctr_dout == LAST);
            oor     <= track_ok && ({1'b0, ctr_dout} >= 5'(MOD));

            if (!chk_en) begin
                state   <= UNSYNC;
                in_sync <= 1'b0;
            end else begin
                case (state)
                    UNSYNC: begin
                        if (ctr_clr || ctr_load) begin
                            state   <= TRACK;
                            in_sync <= 1'b1;
                        end
                    end
                    TRACK: begin
                        state   <= TRACK;
                        in_sync <= 1'b1;
                    end
                    default: begin
                        state   <= UNSYNC;
                        in_sync <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod14_seq_checker.sv
// tb/tb_mod14_seq_checker.sv - directed table-driven bench for mod14_seq_checker
module tb_mod14_seq_checker;

    logic       clock;
    logic       reset_n;
    logic       chk_en;
    logic       err_clr;
    logic       ctr_clr;
    logic       ctr_load;
    logic       ctr_mode;
    logic [3:0] ctr_din;
    logic [3:0] ctr_dout;
    logic       in_sync;
    logic [3:0] expected;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;
    logic       wrap_up;
    logic       wrap_dn;
    logic       oor;

    int n_tests = 0;
    int n_fail  = 0;

    mod14_seq_checker #(.MOD(14), .ERR_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .chk_en     (chk_en),
        .err_clr    (err_clr),
        .ctr_clr    (ctr_clr),
        .ctr_load   (ctr_load),
        .ctr_mode   (ctr_mode),
        .ctr_din    (ctr_din),
        .ctr_dout   (ctr_dout),
        .in_sync    (in_sync),
        .expected   (expected),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .oor        (oor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic       load;
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
        logic       x_sync;
        logic [3:0] x_exp;
        logic       x_pulse;
        logic       x_sticky;
        logic [7:0] x_count;
        logic       x_wu;
        logic       x_wd;
        logic       x_oor;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic load, input logic mode,
                       input logic [3:0] din, input logic [3:0] dout,
                       input logic s, input logic [3:0] e, input logic p,
                       input logic st, input logic [7:0] c,
                       input logic wu, input logic wd, input logic o);
        vec_t v;
        v.clr = clr; v.load = load; v.mode = mode; v.din = din; v.dout = dout;
        v.x_sync = s; v.x_exp = e; v.x_pulse = p; v.x_sticky = st; v.x_count = c;
        v.x_wu = wu; v.x_wd = wd; v.x_oor = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic en, input logic eclr, input logic clr, input logic load,
                         input logic mode, input logic [3:0] din, input logic [3:0] dout);
        chk_en = en; err_clr = eclr; ctr_clr = clr; ctr_load = load;
        ctr_mode = mode; ctr_din = din; ctr_dout = dout;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        chk_en = 1'b1; err_clr = 1'b0; ctr_clr = 1'b0; ctr_load = 1'b0;
        ctr_mode = 1'b1; ctr_din = 4'd0; ctr_dout = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_sync", in_sync, 0);
        chk("rst_expected", expected, 0);
        chk("rst_flags", {err_pulse, err_sticky, wrap_up, wrap_dn, oor}, 0);
        chk("rst_count", err_count, 0);
        reset_n = 1'b1;

        // clear, then count up 0..13,0,1
        add(1,0,1,0,5,   1,0,0,0,0, 0,0,0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] d;
            d = (i < 14) ? 4'(i) : 4'(i - 14);
            add(0,0,1,0,d, 1, (d == 13) ? 4'd0 : d + 4'd1, 0,0,0, (i == 14), 0,0);
        end
        // load 0, count down 0,13,12
        add(0,1,0,0,2,   1,0,0,0,0, 0,0,0);
        add(0,0,0,0,0,   1,13,0,0,0, 0,0,0);
        add(0,0,0,0,13,  1,12,0,0,0, 0,1,0);
        add(0,0,0,0,12,  1,11,0,0,0, 0,0,0);
        // single fault: 7 seen where 5 expected, then 8
        add(0,1,1,4,11,  1,4,0,0,0, 0,0,0);
        add(0,0,1,0,4,   1,5,0,0,0, 0,0,0);
        add(0,0,1,0,7,   1,8,1,1,1, 0,0,0);
        add(0,0,1,0,8,   1,9,0,1,1, 0,0,0);
        // load 15, up: 15 then 0
        add(0,1,1,15,9,  1,15,0,1,1, 0,0,0);
        add(0,0,1,0,15,  1,0,0,1,1, 0,0,1);
        add(0,0,1,0,0,   1,1,0,1,1, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, 1'b0, vecs[i].clr, vecs[i].load, vecs[i].mode, vecs[i].din, vecs[i].dout);
            chk($sformatf("v%0d_in_sync", i), in_sync, vecs[i].x_sync);
            chk($sformatf("v%0d_expected", i), expected, vecs[i].x_exp);
            chk($sformatf("v%0d_err_pulse", i), err_pulse, vecs[i].x_pulse);
            chk($sformatf("v%0d_err_sticky", i), err_sticky, vecs[i].x_sticky);
            chk($sformatf("v%0d_err_count", i), err_count, vecs[i].x_count);
            chk($sformatf("v%0d_wrap_up", i), wrap_up, vecs[i].x_wu);
            chk($sformatf("v%0d_wrap_dn", i), wrap_dn, vecs[i].x_wd);
            chk($sformatf("v%0d_oor", i), oor, vecs[i].x_oor);
        end

        // 300 consecutive mismatches on top of the existing count of 1
        for (int k = 1; k <= 300; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3);
            if (k == 253) chk("sat_253", err_count, 254);
            if (k == 254) chk("sat_254", err_count, 255);
        end
        chk("sat_300_count", err_count, 255);
        chk("sat_300_pulse", err_pulse, 1);
        chk("sat_300_sticky", err_sticky, 1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3);
        chk("clr_mm_count", err_count, 0);
        chk("clr_mm_sticky", err_sticky, 0);
        chk("clr_mm_pulse", err_pulse, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd4);
        chk("after_clr_pulse", err_pulse, 0);
        chk("after_clr_exp", expected, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
        chk("pre_rst_count", err_count, 1);

        // asynchronous reset between edges
        reset_n = 1'b0;
        #1;
        chk("arst_in_sync", in_sync, 0);
        chk("arst_expected", expected, 0);
        chk("arst_count", err_count, 0);
        chk("arst_flags", {err_pulse, err_sticky, wrap_up, wrap_dn, oor}, 0);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7);
            chk("unsync_in_sync", in_sync, 0);
            chk("unsync_pulse", err_pulse, 0);
        end
        chk("unsync_exp", expected, 8);
        chk("unsync_count", err_count, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd7);
        chk("reload_in_sync", in_sync, 1);
        chk("reload_exp", expected, 9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
        chk("reload_ok_pulse", err_pulse, 0);
        chk("reload_ok_exp", expected, 10);

        // chk_en low drops sync, even with a load present
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2);
        chk("dis_in_sync", in_sync, 0);
        chk("dis_pulse", err_pulse, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd3);
        chk("dis_load_in_sync", in_sync, 0);
        chk("dis_load_exp", expected, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd6);
        chk("en_noload_in_sync", in_sync, 0);
        chk("en_noload_pulse", err_pulse, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd6);
        chk("en_load_in_sync", in_sync, 1);
        chk("en_load_exp", expected, 9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
        chk("en_track_ok", err_pulse, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd11);
        chk("en_track_err_pulse", err_pulse, 1);
        chk("en_track_err_count", err_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
